// File: rtl/sobel_window.sv
// Streaming 3x3 window generator: two line buffers plus three 2-deep column taps turn a
// raster pixel stream into one registered window per accepted pixel, then flush the last row.
module sobel_window #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_pix,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    output logic [7:0] pix_0,
    output logic [7:0] pix_1,
    output logic [7:0] pix_2,
    output logic [7:0] pix_3,
    output logic [7:0] pix_5,
    output logic [7:0] pix_6,
    output logic [7:0] pix_7,
    output logic [7:0] pix_8,
    output logic       win_valid,
    output logic       win_border,
    output logic       win_last,
    output logic       sync_err
);
    localparam int DATA_W = 8;
    localparam int CW     = $clog2(WIDTH);
    localparam int RW     = $clog2(HEIGHT);
    localparam int FW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [FW-1:0]     fcnt;
    logic [DATA_W-1:0] lb_top [WIDTH];
    logic [DATA_W-1:0] lb_mid [WIDTH];
    logic [DATA_W-1:0] top_rd, mid_rd;
    logic [DATA_W-1:0] top_p1, top_p2, mid_p1, mid_p2, bot_p1, bot_p2;
    logic [CW-1:0]     wcol;
    logic accept, start, advance, store, err;
    logic emit_run, emit_flush, run_last, interior;

    assign in_ready   = (state != FLUSH);
    assign accept     = in_valid & in_ready;
    assign start      = accept & in_sof;
    assign advance    = accept & (state == RUN) & ~in_sof;
    assign store      = start | advance;
    assign err        = accept & (((state == IDLE) & ~in_sof) | ((state == RUN) & in_sof));
    // Accepting (r,c) completes the window centred one row up and one column left;
    // column 0 closes the previous centre row, so row 1 col 0 has nothing to emit.
    assign emit_run   = advance & (row != '0) & ~((row == RW'(1)) & (col == '0));
    assign run_last   = advance & (row == ROW_LAST) & (col == COL_LAST);
    assign emit_flush = (state == FLUSH);
    assign interior   = emit_run & (row >= RW'(2)) & (col >= CW'(2));
    assign wcol       = start ? '0 : col;
    assign top_rd     = lb_top[wcol];
    assign mid_rd     = lb_mid[wcol];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (run_last) state_nxt = FLUSH;
            FLUSH:   if (fcnt == FLUSH_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col  <= '0;
            row  <= '0;
            fcnt <= '0;
        end else begin
            if (start) begin
                col <= CW'(1);
                row <= '0;
            end else if (advance) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            fcnt <= emit_flush ? fcnt + 1'b1 : '0;
        end
    end

    // stage p0 -> p1/p2: line buffers shift one row up, column taps shift one column left
    always_ff @(posedge clk) begin
        if (store) begin
            lb_top[wcol] <= mid_rd;
            lb_mid[wcol] <= in_pix;
            top_p1 <= top_rd;
            top_p2 <= top_p1;
            mid_p1 <= mid_rd;
            mid_p2 <= mid_p1;
            bot_p1 <= in_pix;
            bot_p2 <= bot_p1;
        end
    end

    // output stage: one registered window per emit, pixels held between windows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid  <= 1'b0;
            win_border <= 1'b0;
            win_last   <= 1'b0;
            sync_err   <= 1'b0;
            pix_0 <= '0;
            pix_1 <= '0;
            pix_2 <= '0;
            pix_3 <= '0;
            pix_5 <= '0;
            pix_6 <= '0;
            pix_7 <= '0;
            pix_8 <= '0;
        end else begin
            win_valid  <= emit_run | emit_flush;
            win_border <= (emit_run & ~interior) | emit_flush;
            win_last   <= emit_flush & (fcnt == FLUSH_LAST);
            sync_err   <= err;
            if (emit_run | emit_flush) begin
                pix_0 <= interior ? top_p2 : '0;
                pix_1 <= interior ? top_p1 : '0;
                pix_2 <= interior ? top_rd : '0;
                pix_3 <= interior ? mid_p2 : '0;
                pix_5 <= interior ? mid_rd : '0;
                pix_6 <= interior ? bot_p2 : '0;
                pix_7 <= interior ? bot_p1 : '0;
                pix_8 <= interior ? in_pix : '0;
            end
        end
    end
endmodule

// File: tb/tb_sobel_window.sv
// Bench for sobel_window: a 4x3 instance driven from a vector table and directed sequences,
// and a default-size instance streaming ramp frames checked by an index-based window model.
module tb_sobel_window;
    localparam int BW = 128;
    localparam int BH = 96;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        border;
        logic        last;
        logic [63:0] pix;
    } win_t;
    typedef struct {
        logic [7:0] pix_in;
        logic       sof;
        win_t       exp;
    } vec_t;
    vec_t tab[12];

    // ---------------- small instance ----------------
    logic       a_rst, a_in_valid, a_in_sof;
    logic [7:0] a_in_pix;
    logic       a_in_ready, a_win_valid, a_win_border, a_win_last, a_sync_err;
    logic [7:0] a_p0, a_p1, a_p2, a_p3, a_p5, a_p6, a_p7, a_p8;

    sobel_window #(.WIDTH(4), .HEIGHT(3)) dut_a (
        .clk(clk), .rst(a_rst), .in_pix(a_in_pix), .in_valid(a_in_valid), .in_sof(a_in_sof),
        .in_ready(a_in_ready), .pix_0(a_p0), .pix_1(a_p1), .pix_2(a_p2), .pix_3(a_p3),
        .pix_5(a_p5), .pix_6(a_p6), .pix_7(a_p7), .pix_8(a_p8), .win_valid(a_win_valid),
        .win_border(a_win_border), .win_last(a_win_last), .sync_err(a_sync_err)
    );

    win_t a_q[$];
    int   a_win_cyc[$];
    int   a_nerr = 0;
    int   a_nready_low = 0;

    always @(negedge clk) begin
        if (a_rst) begin
            if (a_win_valid) begin
                a_q.push_back({a_win_border, a_win_last, a_p0, a_p1, a_p2, a_p3, a_p5, a_p6, a_p7, a_p8});
                a_win_cyc.push_back(cyc);
            end
            if (a_sync_err) a_nerr++;
            if (!a_in_ready) a_nready_low++;
        end
    end

    // ---------------- default-size instance ----------------
    logic       b_rst, b_in_valid, b_in_sof;
    logic [7:0] b_in_pix;
    logic       b_in_ready, b_win_valid, b_win_border, b_win_last, b_sync_err;
    logic [7:0] b_p0, b_p1, b_p2, b_p3, b_p5, b_p6, b_p7, b_p8;

    sobel_window dut_b (
        .clk(clk), .rst(b_rst), .in_pix(b_in_pix), .in_valid(b_in_valid), .in_sof(b_in_sof),
        .in_ready(b_in_ready), .pix_0(b_p0), .pix_1(b_p1), .pix_2(b_p2), .pix_3(b_p3),
        .pix_5(b_p5), .pix_6(b_p6), .pix_7(b_p7), .pix_8(b_p8), .win_valid(b_win_valid),
        .win_border(b_win_border), .win_last(b_win_last), .sync_err(b_sync_err)
    );

    function automatic logic [7:0] rp(int y, int x);
        return 8'((y + x) & 255);
    endfunction

    int   b_k = 0, b_nwin = 0, b_nlast = 0, b_nerr = 0, b_bad = 0, b_late = 0;
    logic b_acc_prev = 1'b0, b_sof_prev = 1'b0;

    always @(negedge clk) begin
        if (b_rst) begin
            win_t got, want;
            int   y, x;
            if (b_acc_prev && b_sof_prev) b_k = 0;
            if (b_win_valid) begin
                y = b_k / BW;
                x = b_k % BW;
                want.border = (y == 0) || (y == BH - 1) || (x == 0) || (x == BW - 1);
                want.last   = (b_k == BW * BH - 1);
                want.pix    = want.border ? 64'd0 :
                              {rp(y-1, x-1), rp(y-1, x), rp(y-1, x+1), rp(y, x-1),
                               rp(y, x+1), rp(y+1, x-1), rp(y+1, x), rp(y+1, x+1)};
                got = {b_win_border, b_win_last, b_p0, b_p1, b_p2, b_p3, b_p5, b_p6, b_p7, b_p8};
                if (got !== want) begin
                    b_bad++;
                    if (b_bad <= 3) $display("b_window detail k=%0d got=%h want=%h", b_k, got, want);
                end
                if (b_k < BW * BH - BW - 1 && !b_acc_prev) b_late++;
                if (b_win_last) b_nlast++;
                b_k++;
                b_nwin++;
            end
            if (b_sync_err) b_nerr++;
        end
        b_acc_prev = b_in_valid & b_in_ready;
        b_sof_prev = b_in_sof;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic a_send(input logic [7:0] p, input logic sof);
        bit ok = 0;
        a_in_pix = p; a_in_sof = sof; a_in_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (a_in_ready) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL a_send_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_sof = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] p, input logic sof);
        bit ok = 0;
        if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        b_in_pix = p; b_in_sof = sof; b_in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (b_in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL b_send_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_sof = 1'b0;
    endtask

    task automatic a_run_table(input string tag);
        int base = a_q.size();
        int r0   = a_nready_low;
        for (int i = 0; i < 12; i++) a_send(tab[i].pix_in, tab[i].sof);
        repeat (10) @(posedge clk);
        #1;
        chk({tag, "_nwin"}, 96'(a_q.size() - base), 96'(12));
        chk({tag, "_ready_low"}, 96'(a_nready_low - r0), 96'(5));
        for (int i = 0; i < 12; i++) begin
            if (base + i < a_q.size()) begin
                chk($sformatf("%s_win%0d", tag, i), 96'(a_q[base + i]), 96'(tab[i].exp));
            end else begin
                checks++;
                failures++;
                $display("FAIL %s_win%0d actual=missing required=%0h", tag, i, tab[i].exp);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, e0, nl;
        for (int k = 0; k < 12; k++) begin
            tab[k].pix_in = 8'(k);
            tab[k].sof    = (k == 0);
            tab[k].exp    = '{border: 1'b1, last: (k == 11), pix: 64'd0};
        end
        tab[5].exp.border = 1'b0;
        tab[5].exp.pix    = {8'd0, 8'd1, 8'd2, 8'd4, 8'd6, 8'd8, 8'd9, 8'd10};
        tab[6].exp.border = 1'b0;
        tab[6].exp.pix    = {8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd9, 8'd10, 8'd11};

        a_rst = 0; a_in_valid = 0; a_in_sof = 0; a_in_pix = '0;
        b_rst = 0; b_in_valid = 0; b_in_sof = 0; b_in_pix = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 96'(a_in_ready), 96'(1));
        chk("rst_flags", 96'({a_win_valid, a_win_border, a_win_last, a_sync_err}), 96'(0));
        chk("rst_pix", 96'({a_p0, a_p1, a_p2, a_p3, a_p5, a_p6, a_p7, a_p8}), 96'(0));
        @(negedge clk);
        a_rst = 1; b_rst = 1;
        @(posedge clk); #1;

        a_run_table("frame1");

        // pixels without start-of-frame while idle
        e0 = a_nerr; base = a_q.size();
        for (int i = 0; i < 3; i++) a_send(8'(50 + i), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_nosof_err", 96'(a_nerr - e0), 96'(3));
        chk("idle_nosof_nwin", 96'(a_q.size() - base), 96'(0));
        a_run_table("after_nosof");

        // back-to-back frames, continuous valid
        base = a_q.size();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 12; i++) a_send(tab[i].pix_in, tab[i].sof);
        repeat (10) @(posedge clk);
        #1;
        chk("b2b_nwin", 96'(a_q.size() - base), 96'(24));
        if (a_q.size() >= base + 24) begin
            nl = 0;
            for (int i = 0; i < 24; i++) nl += int'(a_q[base + i].last);
            chk("b2b_nlast", 96'(nl), 96'(2));
            chk("b2b_gap", 96'(a_win_cyc[base + 12] - a_win_cyc[base + 11]), 96'(6));
            chk("b2b_win17", 96'(a_q[base + 17]), 96'(tab[5].exp));
        end

        // reset while flushing
        for (int i = 0; i < 12; i++) a_send(tab[i].pix_in, tab[i].sof);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!a_in_ready) break;
        end
        a_rst = 0;
        #1;
        chk("flush_rst_valid", 96'({a_win_valid, a_win_border, a_win_last}), 96'(0));
        chk("flush_rst_pix", 96'({a_p0, a_p1, a_p2, a_p3, a_p5, a_p6, a_p7, a_p8}), 96'(0));
        chk("flush_rst_ready", 96'(a_in_ready), 96'(1));
        @(negedge clk);
        a_rst = 1;
        base = a_q.size();
        repeat (10) @(posedge clk);
        #1;
        chk("flush_rst_nowin", 96'(a_q.size() - base), 96'(0));
        a_run_table("after_rst");

        // full-size ramp frame, aborted frame, then a clean frame, all with valid gaps
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++) b_send(rp(y, x), (y == 0 && x == 0));
        for (int i = 0; i < 2 * BW + 5; i++) b_send(rp(i / BW, i % BW), (i == 0));
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++) b_send(rp(y, x), (y == 0 && x == 0));
        repeat (BW + 10) @(posedge clk);
        #1;
        chk("ramp_nwin", 96'(b_nwin), 96'(2 * BW * BH + (BW - 1) + 5));
        chk("ramp_nlast", 96'(b_nlast), 96'(2));
        chk("ramp_sync_err", 96'(b_nerr), 96'(1));
        chk("ramp_content_bad", 96'(b_bad), 96'(0));
        chk("ramp_latency_bad", 96'(b_late), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
